// File: rtl/t_inst_seq.sv
// t_inst_seq: LFSR stimulus sequencer and self-checker for the inverter datapath
module t_inst_seq #(
  parameter int NUM_CYCLES = 16,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         start,
  output logic         drv_seq,
  output logic         drv_com,
  output logic [1:0]   drv2_com,
  output logic [127:0] drv_wide,
  input  logic         mon_seq_d1r,
  input  logic         mon_com,
  input  logic [1:0]   mon2_com,
  output logic         busy,
  output logic         done,
  output logic         fail,
  output logic [7:0]   err_count,
  output logic [7:0]   cyc_count
);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, FAIL} state_t;
  localparam logic [7:0] seed_v = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] last_cyc = 8'(NUM_CYCLES - 1);
  state_t state, state_nx;
  logic [7:0] lfsr, drv_src, err_nx;
  logic exp_seq, exp_valid, go, mis;
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    busy = (state == RUN) || (state == DRAIN);
    done = state == DONE;
    fail = state == FAIL;
    go = start && !busy;
    drv_src = go ? seed_v : lfsr;
    mis = busy && ((mon_com != ~drv_com) || (mon2_com != ~drv2_com) ||
                   (exp_valid && (mon_seq_d1r != exp_seq)));
    err_nx = (mis && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    state_nx = go ? RUN :
               (state == RUN && cyc_count == last_cyc) ? DRAIN :
               (state == DRAIN) ? ((err_nx == 8'd0) ? DONE : FAIL) : state;
  end
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      lfsr <= seed_v;
      {drv_wide, drv2_com, drv_com, drv_seq} <= '0;
      exp_seq <= 1'b0;
      exp_valid <= 1'b0;
      err_count <= '0;
      cyc_count <= '0;
    end else begin
      if (go || state == RUN) begin
        {drv_wide, drv2_com, drv_com, drv_seq} <= {{16{drv_src}}, drv_src[3:0]};
        lfsr <= lfsr_step(drv_src);
      end
      if (go) begin
        cyc_count <= '0;
        err_count <= '0;
        exp_valid <= 1'b0;
      end else if (state == RUN) begin
        exp_seq <= ~drv_seq;
        exp_valid <= 1'b1;
        cyc_count <= cyc_count + 8'd1;
      end
      if (busy) err_count <= err_nx;
    end
endmodule

// File: tb/tb_t_inst_seq.sv
// tb_t_inst_seq: directed bench for t_inst_seq with an inverter datapath model per instance
module tb_t_inst_seq;
  localparam int nc [3] = '{16, 255, 16};
  localparam logic [7:0] sd [3] = '{8'hA5, 8'hA5, 8'h00};
  logic clk = 1'b0;
  logic reset_l = 1'b1;
  logic start [3];
  logic fault_com [3];
  logic fault_byp [3];
  logic drv_seq [3];
  logic drv_com [3];
  logic mon_seq [3];
  logic mon_com [3];
  logic busy [3];
  logic done [3];
  logic fail [3];
  logic dp_reg [3];
  logic [1:0] drv2_com [3];
  logic [1:0] mon2_com [3];
  logic [127:0] drv_wide [3];
  logic [7:0] err_count [3];
  logic [7:0] cyc_count [3];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    t_inst_seq #(.NUM_CYCLES(nc[g]), .SEED(sd[g])) u_dut (
      .clk(clk), .reset_l(reset_l), .start(start[g]),
      .drv_seq(drv_seq[g]), .drv_com(drv_com[g]), .drv2_com(drv2_com[g]), .drv_wide(drv_wide[g]),
      .mon_seq_d1r(mon_seq[g]), .mon_com(mon_com[g]), .mon2_com(mon2_com[g]),
      .busy(busy[g]), .done(done[g]), .fail(fail[g]),
      .err_count(err_count[g]), .cyc_count(cyc_count[g])
    );
  end
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) dp_reg <= '{default: 1'b0};
    else for (int i = 0; i < 3; i++) dp_reg[i] <= ~drv_seq[i];
  always_comb
    for (int i = 0; i < 3; i++) begin
      mon_com[i] = fault_com[i] ? drv_com[i] : ~drv_com[i];
      mon2_com[i] = ~drv2_com[i];
      mon_seq[i] = fault_byp[i] ? ~drv_seq[i] : dp_reg[i];
    end
  function automatic logic [7:0] step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask
  task automatic run(input int i, input logic [7:0] seed, input int exp_busy);
    logic [7:0] d;
    int n;
    @(negedge clk) start[i] = 1'b1;
    @(negedge clk) start[i] = 1'b0;
    d = seed;
    n = 0;
    while (busy[i] && n < 300) begin
      chk("drivers", {drv_wide[i], drv2_com[i], drv_com[i], drv_seq[i]}, {{16{d}}, d[3:2], d[1], d[0]});
      d = step(d);
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, exp_busy);
  endtask
  task automatic result(input int i, input logic dn, input logic fl, input logic [7:0] ec, input logic [7:0] cc);
    chk("done", done[i], dn);
    chk("fail", fail[i], fl);
    chk("err_count", err_count[i], ec);
    chk("cyc_count", cyc_count[i], cc);
    chk("busy_after", busy[i], 1'b0);
  endtask
  initial begin
    int n;
    int exp_err;
    logic [7:0] d, dn;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      fault_com[i] = 1'b0;
      fault_byp[i] = 1'b0;
    end
    #1 reset_l = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("reset_drv", {drv_wide[i], drv2_com[i], drv_com[i], drv_seq[i]}, '0);
      chk("reset_stat", {busy[i], done[i], fail[i], err_count[i], cyc_count[i]}, '0);
    end
    @(negedge clk) reset_l = 1'b1;
    run(0, 8'hA5, 17);
    result(0, 1'b1, 1'b0, 8'd0, 8'd16);
    fault_com[0] = 1'b1;
    run(0, 8'hA5, 17);
    result(0, 1'b0, 1'b1, 8'd17, 8'd16);
    fault_com[0] = 1'b0;
    fault_byp[0] = 1'b1;
    d = 8'hA5;
    exp_err = 0;
    for (int k = 1; k <= 16; k++) begin
      dn = step(d);
      if (dn[0] != d[0]) exp_err++;
      d = dn;
    end
    run(0, 8'hA5, 17);
    result(0, 1'b0, 1'b1, 8'(exp_err), 8'd16);
    chk("bypass_nonzero", exp_err != 0, 1'b1);
    fault_byp[0] = 1'b0;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_l = 1'b0;
    #1;
    chk("midrun_rst_drv", {drv_wide[0], drv2_com[0], drv_com[0], drv_seq[0]}, '0);
    chk("midrun_rst_stat", {busy[0], done[0], fail[0], err_count[0], cyc_count[0]}, '0);
    @(negedge clk) reset_l = 1'b1;
    run(0, 8'hA5, 17);
    result(0, 1'b1, 1'b0, 8'd0, 8'd16);
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy[0] && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("held_busy_len", n, 17);
    chk("held_done", done[0], 1'b1);
    @(negedge clk);
    chk("restart_busy", busy[0], 1'b1);
    chk("restart_done", done[0], 1'b0);
    chk("restart_drv", drv_wide[0], {16{8'hA5}});
    start[0] = 1'b0;
    n = 0;
    while (busy[0] && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("restart_done2", done[0], 1'b1);
    fault_com[1] = 1'b1;
    run(1, 8'hA5, 256);
    result(1, 1'b0, 1'b1, 8'd255, 8'd255);
    run(2, 8'h01, 17);
    result(2, 1'b1, 1'b0, 8'd0, 8'd16);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
